// File: rtl/config_frame_loader.sv
// Configuration frame loader: hunts for a sync word, then turns header/data word pairs
// into a SETUP/STROBE/HOLD latch-write sequence on the addressed column and frame.
module config_frame_loader #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_COLS       = 16,
    parameter int unsigned FRAMES_PER_COL = 20,
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic [31:0]               s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [DATA_W-1:0]         FrameData,
    output logic [NUM_COLS-1:0]       ColSelect,
    output logic [FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [15:0]               frame_count
);

    typedef enum logic [2:0] {
        HUNT,
        HEADER,
        DATA,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    // One extra bit so a full 256-entry range still compares correctly.
    localparam logic [8:0] COL_LIM = 9'(NUM_COLS);
    localparam logic [8:0] FRM_LIM = 9'(FRAMES_PER_COL);

    state_t     state;
    logic [7:0] col_q;
    logic [7:0] frm_q;
    logic       accept;
    logic       addr_bad;

    // Only word-consuming states are ready; reset masks ready so no word is lost.
    assign s_ready  = resetn && (state == HUNT || state == HEADER || state == DATA);
    assign accept   = s_valid && s_ready;
    assign addr_bad = ({1'b0, col_q} >= COL_LIM) || ({1'b0, frm_q} >= FRM_LIM);

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state       <= HUNT;
            col_q       <= '0;
            frm_q       <= '0;
            FrameData   <= '0;
            ColSelect   <= '0;
            FrameStrobe <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            frame_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                HUNT: begin
                    if (accept && s_data == SYNC_WORD) begin
                        state       <= HEADER;
                        busy        <= 1'b1;
                        error       <= 1'b0;
                        frame_count <= '0;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        if (s_data[31]) begin
                            state <= HUNT;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            col_q <= s_data[23:16];
                            frm_q <= s_data[7:0];
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (addr_bad) begin
                            state <= HUNT;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            FrameData <= DATA_W'(s_data);
                            ColSelect <= NUM_COLS'(1) << col_q;
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    FrameStrobe <= FRAMES_PER_COL'(1) << frm_q;
                    if (frame_count != '1) begin
                        frame_count <= frame_count + 16'd1;
                    end
                    state <= STROBE;
                end
                STROBE: begin
                    FrameStrobe <= '0;
                    state       <= HOLD;
                end
                HOLD: begin
                    ColSelect <= '0;
                    state     <= HEADER;
                end
                default: begin
                    state       <= HUNT;
                    busy        <= 1'b0;
                    ColSelect   <= '0;
                    FrameStrobe <= '0;
                end
            endcase
        end
    end

endmodule
